mvm_cmd_tx: RTL

MVM_CMD_TX -- requirements
Module: mvm_cmd_tx

---
 rtl/mvm_cmd_tx_pkg.sv | 38 +++
 rtl/mvm_cmd_tx_if.sv | 41 ++++
 rtl/mvm_cmd_tx_axis_out_reg.sv | 85 ++++++++
 rtl/mvm_cmd_tx.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/mvm_cmd_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mvm_cmd_tx_pkg
// Purpose  : Shared definitions for the MVM command transmitter: op codes,
//            tuser field layout, default bus widths and the FSM state type.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mvm_cmd_tx_pkg;

    // Default widths of the command transmitter and its AXI-Stream output
    localparam int DEF_DATAW   = 512;
    localparam int DEF_BYTEW   = 8;
    localparam int DEF_IDW     = 32;
    localparam int DEF_DESTW   = 12;
    localparam int DEF_USERW   = 75;
    localparam int DEF_RFADDRW = 9;
    localparam int DEF_MASKW   = 64;
    localparam int DEF_LENW    = 6;

    // Command op encodings as understood by the rtl_mvm receiver
    localparam logic [1:0] OP_RF   = 2'b11;
    localparam logic [1:0] OP_IVEC = 2'b10;
    localparam logic [1:0] OP_RVEC = 2'b01;
    localparam logic [1:0] OP_INST = 2'b00;

    // tuser layout: {mask, op, beat address}
    localparam int TUSER_ADDR_LSB = 0;
    localparam int TUSER_OP_LSB   = 9;
    localparam int TUSER_MASK_LSB = 11;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mvm_cmd_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : mvm_cmd_tx_if
// Purpose  : AXI-Stream bus carrying MVM packets toward the rtl_mvm rx port.
// Ports    : master - drives tvalid/tdata/tstrb/tkeep/tid/tdest/tuser/tlast,
//                     samples tready
//            slave  - the mirror image
// Revision : 1.0 - initial release
// ============================================================================
interface mvm_cmd_tx_if
    import mvm_cmd_tx_pkg::*;
#(
    parameter int DATAW = DEF_DATAW,
    parameter int BYTEW = DEF_BYTEW,
    parameter int IDW   = DEF_IDW,
    parameter int DESTW = DEF_DESTW,
    parameter int USERW = DEF_USERW
) ();

    logic             tvalid;
    logic             tready;
    logic [DATAW-1:0] tdata;
    logic [BYTEW-1:0] tstrb;
    logic [BYTEW-1:0] tkeep;
    logic [IDW-1:0]   tid;
    logic [DESTW-1:0] tdest;
    logic [USERW-1:0] tuser;
    logic             tlast;

    modport master (
        output tvalid, tdata, tstrb, tkeep, tid, tdest, tuser, tlast,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tstrb, tkeep, tid, tdest, tuser, tlast,
        output tready
    );

endinterface
`default_nettype wire

// File: rtl/mvm_cmd_tx_axis_out_reg.sv
`default_nettype none
// ============================================================================
// Module   : axis_out_reg
// Purpose  : One-entry valid/ready holding register driving the AXI-Stream
//            output. Loads a beat when empty or when the held beat leaves in
//            the same cycle, so a continuous tready gives one beat per cycle.
//            Also owns the tid beat counter.
// Ports    : clk, rst (async, active-low)
//            in_valid/in_ready  - upstream beat handshake
//            in_data/in_user/in_dest - beat payload
//            held               - a beat is sitting in the register
//            tx                 - AXI-Stream master
// Revision : 1.0 - initial release
// ============================================================================
module axis_out_reg
    import mvm_cmd_tx_pkg::*;
#(
    parameter int DATAW = DEF_DATAW,
    parameter int BYTEW = DEF_BYTEW,
    parameter int IDW   = DEF_IDW,
    parameter int DESTW = DEF_DESTW,
    parameter int USERW = DEF_USERW
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             in_valid,
    output logic                  in_ready,
    input  wire logic [DATAW-1:0] in_data,
    input  wire logic [USERW-1:0] in_user,
    input  wire logic [DESTW-1:0] in_dest,
    output logic                  held,
    mvm_cmd_tx_if.master          tx
);

    logic             r_valid;
    logic [DATAW-1:0] r_data;
    logic [USERW-1:0] r_user;
    logic [DESTW-1:0] r_dest;
    logic [IDW-1:0]   r_tid;
    logic             w_load;

    assign in_ready = !r_valid || tx.tready;
    assign w_load   = in_valid && in_ready;

    // Payload registers only change on a load, which can only happen once the
    // held beat has been taken, so a stalled beat stays frozen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_user  <= '0;
            r_dest  <= '0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_data  <= in_data;
            r_user  <= in_user;
            r_dest  <= in_dest;
        end else if (tx.tready) begin
            r_valid <= 1'b0;
        end
    end

    // tid is the number of beats already taken downstream; it only advances
    // on a handshake, so it is stable for a held beat and is already bumped
    // when a replacement beat loads in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tid <= '0;
        end else if (r_valid && tx.tready) begin
            r_tid <= r_tid + 1'b1;
        end
    end

    assign tx.tvalid = r_valid;
    assign tx.tdata  = r_data;
    assign tx.tuser  = r_user;
    assign tx.tdest  = r_dest;
    assign tx.tid    = r_tid;
    assign tx.tlast  = r_valid;
    assign tx.tstrb  = r_valid ? {BYTEW{1'b1}} : {BYTEW{1'b0}};
    assign tx.tkeep  = r_valid ? {BYTEW{1'b1}} : {BYTEW{1'b0}};
    assign held      = r_valid;

endmodule
`default_nettype wire

// File: rtl/mvm_cmd_tx.sv
`default_nettype none
// ============================================================================
// Module   : mvm_cmd_tx
// Purpose  : Turns a burst command plus a stream of payload beats into
//            single-beat AXI-Stream packets for rtl_mvm, tagging each beat
//            with its RF address, op and lane mask in tuser.
// Ports    : clk, rst (async, active-low)
//            cmd_valid/cmd_ready, cmd_op, cmd_addr, cmd_len, cmd_mask,
//            cmd_dest           - burst command
//            dat_valid/dat_ready, dat_tdata - payload beats
//            axis_tx            - AXI-Stream master (interface)
//            busy               - burst in progress or beat still held
// Revision : 1.0 - initial release
// ============================================================================
module mvm_cmd_tx
    import mvm_cmd_tx_pkg::*;
#(
    parameter int DATAW   = DEF_DATAW,
    parameter int BYTEW   = DEF_BYTEW,
    parameter int IDW     = DEF_IDW,
    parameter int DESTW   = DEF_DESTW,
    parameter int USERW   = DEF_USERW,
    parameter int RFADDRW = DEF_RFADDRW,
    parameter int MASKW   = DEF_MASKW,
    parameter int LENW    = DEF_LENW
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               cmd_valid,
    output logic                    cmd_ready,
    input  wire logic [1:0]         cmd_op,
    input  wire logic [RFADDRW-1:0] cmd_addr,
    input  wire logic [LENW-1:0]    cmd_len,
    input  wire logic [MASKW-1:0]   cmd_mask,
    input  wire logic [DESTW-1:0]   cmd_dest,
    input  wire logic               dat_valid,
    output logic                    dat_ready,
    input  wire logic [DATAW-1:0]   dat_tdata,
    mvm_cmd_tx_if.master            axis_tx,
    output logic                    busy
);

    // A length field of zero stands for the longest burst, 2^LENW beats
    localparam logic [LENW:0] C_MAX_BURST = {1'b1, {LENW{1'b0}}};
    localparam logic [LENW:0] C_ONE       = {{LENW{1'b0}}, 1'b1};

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_op;
    logic [RFADDRW-1:0] r_addr;
    logic [LENW:0]      r_remain;
    logic [MASKW-1:0]   r_mask;
    logic [DESTW-1:0]   r_dest;

    logic               w_cmd_fire;
    logic               w_beat_fire;
    logic               w_out_valid;
    logic               w_out_ready;
    logic               w_out_held;
    logic [USERW-1:0]   w_user;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // cmd_ready is gated by rst so it reads low while reset is held.
    always_comb begin
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        dat_ready   = 1'b0;
        w_cmd_fire  = 1'b0;
        w_beat_fire = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cmd_ready  = rst;
                w_cmd_fire = cmd_valid && rst;
                if (w_cmd_fire) begin
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                dat_ready   = w_out_ready;
                w_out_valid = dat_valid;
                w_beat_fire = dat_valid && w_out_ready;
                if (w_beat_fire && (r_remain == C_ONE)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Burst context: r_addr always holds the address of the next beat and
    // wraps naturally at 2^RFADDRW.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op     <= '0;
            r_addr   <= '0;
            r_remain <= '0;
            r_mask   <= '0;
            r_dest   <= '0;
        end else if (w_cmd_fire) begin
            r_op     <= cmd_op;
            r_addr   <= cmd_addr;
            r_remain <= (cmd_len == '0) ? C_MAX_BURST : {1'b0, cmd_len};
            r_mask   <= cmd_mask;
            r_dest   <= cmd_dest;
        end else if (w_beat_fire) begin
            r_addr   <= r_addr + 1'b1;
            r_remain <= r_remain - 1'b1;
        end
    end

    // Field offsets assume the default 9-bit RF address width
    always_comb begin
        w_user                                = '0;
        w_user[TUSER_ADDR_LSB +: RFADDRW]     = r_addr;
        w_user[TUSER_OP_LSB +: 2]             = r_op;
        w_user[TUSER_MASK_LSB +: MASKW]       = r_mask;
    end

    axis_out_reg #(
        .DATAW (DATAW),
        .BYTEW (BYTEW),
        .IDW   (IDW),
        .DESTW (DESTW),
        .USERW (USERW)
    ) u_out_reg (
        .clk      (clk),
        .rst      (rst),
        .in_valid (w_out_valid),
        .in_ready (w_out_ready),
        .in_data  (dat_tdata),
        .in_user  (w_user),
        .in_dest  (r_dest),
        .held     (w_out_held),
        .tx       (axis_tx)
    );

    assign busy = (r_state == ST_SEND) || w_out_held;

endmodule
`default_nettype wire
